// File: rtl/pipe_delay_chain.sv
// Elastic valid/ready delay line: STAGES register slices with back-pressure, bubble collapsing
// and synchronous flush. Define PIPE_DELAY_CHAIN_COUNT_EN to build the occupancy counter.
module pipe_delay_chain #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CW     = $clog2(STAGES + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_d,
  output logic [CW-1:0]    o_count
);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] src_valid;
  logic [WIDTH-1:0]  src_data [STAGES];

  // A stage is ready when it or any stage after it is empty, or the consumer takes data.
  always_comb begin
    logic acc;
    acc = i_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      acc    = acc | ~valid_q[k];
      rdy[k] = acc;
    end
  end

  always_comb begin
    src_valid[0] = i_valid;
    src_data[0]  = i_d;
    for (int k = 1; k < int'(STAGES); k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      valid_d[k] = rdy[k] ? src_valid[k] : valid_q[k];
      data_d[k]  = (rdy[k] && src_valid[k]) ? src_data[k] : data_q[k];
    end
    // Flush wins over any load, so an input offered this cycle is dropped.
    if (i_flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_ready = rdy[0];
  assign o_valid = valid_q[STAGES-1];
  assign o_d     = data_q[STAGES-1];

`ifdef PIPE_DELAY_CHAIN_COUNT_EN
  logic [CW-1:0] count_q, count_d;
  logic          in_xfer, out_xfer;

  assign in_xfer  = i_valid && rdy[0];
  assign out_xfer = valid_q[STAGES-1] && i_ready;

  always_comb begin
    count_d = count_q;
    if (i_flush) begin
      count_d = '0;
    end else if (in_xfer && !out_xfer) begin
      count_d = count_q + CW'(1);
    end else if (!in_xfer && out_xfer) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;
`else
  assign o_count = '0;
`endif

endmodule

// File: tb/tb_pipe_delay_chain.sv
// Bench for pipe_delay_chain: STAGES=2 and STAGES=3 instances share one stimulus stream,
// each with its own scoreboard queue. Honours PIPE_DELAY_CHAIN_COUNT_EN for o_count.
module tb_pipe_delay_chain;

`ifdef PIPE_DELAY_CHAIN_COUNT_EN
  localparam bit CountEn = 1'b1;
`else
  localparam bit CountEn = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_d;
  logic       out_ready;

  logic       rdy2, vo2, rdy3, vo3;
  logic [7:0] d2, d3;
  logic [1:0] c2, c3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q2[$];
  logic [7:0] q3[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_delay_chain #(.WIDTH(8), .STAGES(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid), .o_ready(rdy2),
    .i_d(in_d), .o_valid(vo2), .i_ready(out_ready), .o_d(d2), .o_count(c2)
  );

  pipe_delay_chain #(.WIDTH(8), .STAGES(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid), .o_ready(rdy3),
    .i_d(in_d), .o_valid(vo3), .i_ready(out_ready), .o_d(d3), .o_count(c3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check ready/handshakes before the edge, state after it.
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f);
    logic in2, in3, out2, out3;
    @(negedge clk);
    in_valid  = v;
    in_d      = d;
    out_ready = r;
    flush     = f;
    #1;
    check("ready2", 32'(rdy2), 32'(r || (q2.size() < 2)));
    check("ready3", 32'(rdy3), 32'(r || (q3.size() < 3)));
    in2  = v && (r || (q2.size() < 2));
    in3  = v && (r || (q3.size() < 3));
    out2 = vo2 && r;
    out3 = vo3 && r;
    if (out2) begin
      if (q2.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out2: got %0h, expected no output", d2);
      end else begin
        check("data2", 32'(d2), 32'(q2.pop_front()));
      end
    end
    if (out3) begin
      if (q3.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out3: got %0h, expected no output", d3);
      end else begin
        check("data3", 32'(d3), 32'(q3.pop_front()));
      end
    end
    if (f) begin
      q2.delete();
      q3.delete();
    end else begin
      if (in2) q2.push_back(d);
      if (in3) q3.push_back(d);
    end
    @(posedge clk);
    #1;
    check("count2", 32'(c2), CountEn ? 32'(q2.size()) : 32'(0));
    check("count3", 32'(c3), CountEn ? 32'(q3.size()) : 32'(0));
    if (q2.size() == 0) check("empty2", 32'(vo2), 32'(0));
    if (q3.size() == 0) check("empty3", 32'(vo3), 32'(0));
  endtask

  task automatic check_reset_outputs();
    check("rst_valid2", 32'(vo2), 32'(0));
    check("rst_valid3", 32'(vo3), 32'(0));
    check("rst_d2", 32'(d2), 32'(0));
    check("rst_d3", 32'(d3), 32'(0));
    check("rst_count2", 32'(c2), 32'(0));
    check("rst_count3", 32'(c3), 32'(0));
    check("rst_ready2", 32'(rdy2), 32'(1));
    check("rst_ready3", 32'(rdy3), 32'(1));
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       ev2;
    logic [7:0] ed2;
    logic       ev3;
    logic [7:0] ed3;
  } vec_t;

  vec_t tbl[6];

  initial begin
    // Streaming with i_ready=1; expected outputs are the state after each edge.
    tbl[0] = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'h22, 1'b1, 8'h11, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 8'h33, 1'b1, 8'h22, 1'b1, 8'h11};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 8'h22};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h33};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};

    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_d      = 8'h00;
    out_ready = 1'b1;
    #2;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      step(tbl[i].v, tbl[i].d, 1'b1, 1'b0);
      check($sformatf("tbl%0d_valid2", i), 32'(vo2), 32'(tbl[i].ev2));
      check($sformatf("tbl%0d_valid3", i), 32'(vo3), 32'(tbl[i].ev3));
      if (tbl[i].ev2) check($sformatf("tbl%0d_d2", i), 32'(d2), 32'(tbl[i].ed2));
      if (tbl[i].ev3) check($sformatf("tbl%0d_d3", i), 32'(d3), 32'(tbl[i].ed3));
    end

    // Fill and stall: fourth offer must be refused by the 3-stage chain.
    for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    check("full_valid3", 32'(vo3), 32'(1));
    check("full_d3", 32'(d3), 32'hA0);
    check("full_d2", 32'(d2), 32'hA0);
    check("full_ready3", 32'(rdy3), 32'(0));

    // Full chain, simultaneous in and out every cycle.
    for (int i = 0; i < 5; i++) step(1'b1, 8'hB0 + 8'(i), 1'b1, 1'b0);
    check("pass_valid3", 32'(vo3), 32'(1));
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Bubble collapse behind a stalled output stage.
    step(1'b1, 8'hC0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("bub_valid3", 32'(vo3), 32'(1));
    check("bub_d3", 32'(d3), 32'hC0);
    step(1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 8'hC2, 1'b0, 1'b0);
    check("bub_full3", 32'(rdy3), 32'(0));
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain1_d3", 32'(d3), 32'hC1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain2_d3", 32'(d3), 32'hC2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain3_valid3", 32'(vo3), 32'(0));

    // Flush with two items held and an input offered in the flush cycle.
    step(1'b1, 8'hD0, 1'b0, 1'b0);
    step(1'b1, 8'hD1, 1'b0, 1'b0);
    step(1'b1, 8'hD2, 1'b1, 1'b1);
    check("flush_valid2", 32'(vo2), 32'(0));
    check("flush_valid3", 32'(vo3), 32'(0));
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset while the output stage holds data.
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("pre_rst_valid3", 32'(vo3), 32'(1));
    check("pre_rst_d3", 32'(d3), 32'hE0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check_reset_outputs();
    q2.delete();
    q3.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'hF0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst_d3", 32'(d3), 32'hF0);
    repeat (2) step(1'b0, 8'h00, 1'b1, 1'b0);

    check("left2", 32'(q2.size()), 32'(0));
    check("left3", 32'(q3.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
